// File: rtl/hdc_sched_pkg.sv
// Shared types and sizing helpers for the hdc_fusion_scheduler slice.
// Optional statistics counters in the top are enabled with HDC_SCHED_STATS_EN.
`ifndef TOTAL_NUM_CHANNEL
`define TOTAL_NUM_CHANNEL 4
`endif
`ifndef CHANNEL_WIDTH
`define CHANNEL_WIDTH 8
`endif
`ifndef HV_DIMENSION
`define HV_DIMENSION 64
`endif

package hdc_sched_pkg;

  typedef enum logic [1:0] {
    SEED_WAIT = 2'd0,
    SEED_LOAD = 2'd1,
    RUN       = 2'd2
  } sched_state_e;

  function automatic int ceil_log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // A single requester still needs a one-bit tag.
  function automatic int tag_w(input int n);
    return (n < 2) ? 1 : ceil_log2(n);
  endfunction

  function automatic int fifo_ptr_w(input int depth);
    return ceil_log2(depth) + 1;
  endfunction

  localparam int DEF_MAX_INFLIGHT = 4;
  localparam int FIFO_PTR_W       = fifo_ptr_w(DEF_MAX_INFLIGHT);

endpackage

// File: rtl/hdc_sched_tag_fifo.sv
// In-order tag FIFO; pointers carry one extra wrap bit to tell full from empty.
module hdc_sched_tag_fifo
  import hdc_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = fifo_ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic             do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  // A push is refused while full even if a pop frees a slot in the same cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PW'(1);
      if (do_pop)  rd_q <= rd_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/hdc_fusion_scheduler.sv
// Seed loader, round-robin arbiter and in-order result router for one fusion engine.
// Define HDC_SCHED_STATS_EN to add the stat_jobs/stat_stall counters.
`ifndef TOTAL_NUM_CHANNEL
`define TOTAL_NUM_CHANNEL 4
`endif
`ifndef CHANNEL_WIDTH
`define CHANNEL_WIDTH 8
`endif
`ifndef HV_DIMENSION
`define HV_DIMENSION 64
`endif

module hdc_fusion_scheduler
  import hdc_sched_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int FEAT_W       = `TOTAL_NUM_CHANNEL * `CHANNEL_WIDTH,
  parameter int HV_W         = `HV_DIMENSION,
  parameter int MAX_INFLIGHT = 4,
  parameter int SEED_HOLD    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [HV_W-1:0]           seed_in,
  input  logic                      seed_in_valid,
  input  logic [NUM_REQ*FEAT_W-1:0] req_features,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic                      rsp_valence,
  output logic                      rsp_arousal,
  output logic [FEAT_W-1:0]         eng_features,
  output logic                      eng_fin_valid,
  input  logic                      eng_fin_ready,
  input  logic                      eng_valence,
  input  logic                      eng_arousal,
  input  logic                      eng_dout_valid,
  output logic                      eng_dout_ready,
  output logic [HV_W-1:0]           eng_seed_hv,
  output logic                      eng_seed_hv_valid,
  output logic                      busy,
  output logic                      err_orphan
`ifdef HDC_SCHED_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]     stat_jobs,
  output logic [31:0]               stat_stall
`endif
);

  localparam int TAG_W = tag_w(NUM_REQ);
  localparam int CNT_W = ceil_log2(SEED_HOLD + 1);

  sched_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [HV_W-1:0]  seed_q, seed_d;
  logic             seed_vld_q, seed_vld_d;
  logic [TAG_W-1:0] ptr_q, ptr_d;
  logic             orphan_q, orphan_d;

  logic [TAG_W-1:0] grant, head;
  logic             fifo_full, fifo_empty, any_vld, fin_fire, pop;
  int               idx;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    seed_d     = seed_q;
    seed_vld_d = seed_vld_q;
    case (state_q)
      SEED_WAIT: begin
        if (seed_in_valid) begin
          state_d    = SEED_LOAD;
          seed_d     = seed_in;
          seed_vld_d = 1'b1;
          cnt_d      = CNT_W'(SEED_HOLD);
        end
      end
      SEED_LOAD: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d    = RUN;
          seed_vld_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Scan downward so the requester closest to ptr (lowest offset) wins.
  always_comb begin
    grant = '0;
    idx   = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid[TAG_W'(idx)]) grant = TAG_W'(idx);
    end
  end

  always_comb begin
    any_vld       = (state_q == RUN) && (|req_valid);
    eng_fin_valid = any_vld & ~fifo_full;
    fin_fire      = eng_fin_valid & eng_fin_ready;
    eng_features  = req_features[grant*FEAT_W +: FEAT_W];
    req_ready     = '0;
    if (fin_fire) req_ready[grant] = 1'b1;
    ptr_d = ptr_q;
    if (fin_fire) ptr_d = (grant == TAG_W'(NUM_REQ - 1)) ? '0 : grant + TAG_W'(1);

    rsp_valid      = '0;
    if (eng_dout_valid && !fifo_empty) rsp_valid[head] = 1'b1;
    eng_dout_ready = ~fifo_empty & rsp_ready[head];
    pop            = eng_dout_valid & eng_dout_ready;
    orphan_d       = orphan_q | (eng_dout_valid & fifo_empty);
  end

  assign rsp_valence       = eng_valence;
  assign rsp_arousal       = eng_arousal;
  assign eng_seed_hv       = seed_q;
  assign eng_seed_hv_valid = seed_vld_q;
  assign err_orphan        = orphan_q;
  assign busy              = (state_q != RUN) | ~fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SEED_WAIT;
      cnt_q      <= '0;
      seed_q     <= '0;
      seed_vld_q <= 1'b0;
      ptr_q      <= '0;
      orphan_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      seed_q     <= seed_d;
      seed_vld_q <= seed_vld_d;
      ptr_q      <= ptr_d;
      orphan_q   <= orphan_d;
    end
  end

  hdc_sched_tag_fifo #(
    .DEPTH (MAX_INFLIGHT),
    .WIDTH (TAG_W)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fin_fire),
    .pop_i   (pop),
    .din_i   (grant),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef HDC_SCHED_STATS_EN
  logic [15:0] jobs_q [NUM_REQ];
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) jobs_q[i] <= '0;
      stall_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (pop && head == TAG_W'(i) && jobs_q[i] != 16'hFFFF) jobs_q[i] <= jobs_q[i] + 16'd1;
      end
      if (eng_fin_valid && !eng_fin_ready && stall_q != 32'hFFFF_FFFF) stall_q <= stall_q + 32'd1;
    end
  end

  always_comb begin
    stat_jobs = '0;
    for (int i = 0; i < NUM_REQ; i++) stat_jobs[i*16 +: 16] = jobs_q[i];
  end

  assign stat_stall = stall_q;
`endif

endmodule

// File: doc/hdc_fusion_scheduler.md
Name: hdc_fusion_scheduler

Overview:
Sequencer and arbiter in front of one hdc_sensor_fusion engine. Shares the engine between NUM_REQ feature requesters and owns the seed load: it captures a seed, holds seed_hv_valid for SEED_HOLD cycles, then enables inference. It tags every accepted job in an in-order FIFO. Each valence/arousal result is routed back to the requester that issued the job.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
FEAT_W, `TOTAL_NUM_CHANNEL*`CHANNEL_WIDTH, feature vector width
HV_W, `HV_DIMENSION, seed hypervector width
MAX_INFLIGHT, 4, tag FIFO depth (power of 2); maximum jobs inside the engine
SEED_HOLD, 2, cycles eng_seed_hv_valid is held high (>=1)

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous, active-high reset
seed_in  in  HV_W  seed hypervector
seed_in_valid  in  1  seed strobe, sampled only in SEED_WAIT
req_features  in  NUM_REQ*FEAT_W  packed per-requester features; slot i at [i*FEAT_W +: FEAT_W]
req_valid  in  NUM_REQ  per-requester job valid
req_ready  out  NUM_REQ  per-requester accept
rsp_valid  out  NUM_REQ  per-requester result valid
rsp_ready  in  NUM_REQ  per-requester result ready
rsp_valence  out  1  result valence (shared by all requesters)
rsp_arousal  out  1  result arousal (shared by all requesters)
eng_features  out  FEAT_W  to engine features_top
eng_fin_valid  out  1  to engine fin_valid
eng_fin_ready  in  1  from engine fin_ready
eng_valence  in  1  from engine
eng_arousal  in  1  from engine
eng_dout_valid  in  1  from engine
eng_dout_ready  out  1  to engine dout_ready
eng_seed_hv  out  HV_W  to engine seed_hv (registered)
eng_seed_hv_valid  out  1  to engine seed_hv_valid (registered)
busy  out  1  high when state!=RUN or the tag FIFO is non-empty
err_orphan  out  1  sticky; set when eng_dout_valid arrives while the tag FIFO is empty

Behaviour:
- Reset values: all ready/valid outputs 0, eng_seed_hv 0, err_orphan 0, busy 1, FIFO empty, RR pointer 0, state SEED_WAIT.
- A handshake fires on any posedge where valid & ready are both high.
- SEED_WAIT -> SEED_LOAD when seed_in_valid=1. seed_in is latched into eng_seed_hv at that edge.
- SEED_LOAD: eng_seed_hv_valid=1 for exactly SEED_HOLD cycles (down-counter), then state -> RUN.
- RUN is terminal until rst. seed_in_valid is ignored in RUN.
- Reset at any time, including mid-load or with jobs in flight, flushes the FIFO and returns to SEED_WAIT. A new seed is required after every reset.
- Arbitration (RUN only, combinational):
  - The grant goes to the first i with req_valid[i], searching i = ptr, ptr+1, ... modulo NUM_REQ.
  - eng_fin_valid = any req_valid & !fifo_full.
  - eng_features = features of the granted requester.
  - req_ready[g] = eng_fin_ready & !fifo_full; all other req_ready bits are 0.
- On an engine-input fire:
  - push the grant index g into the tag FIFO;
  - ptr <= (g+1) mod NUM_REQ.
- With no fire, ptr holds.
- Arbitration is zero-latency: requester valid to engine valid in the same cycle.
- Return path:
  - h = FIFO head.
  - rsp_valid[h] = eng_dout_valid & !fifo_empty; all other rsp_valid bits are 0.
  - eng_dout_ready = !fifo_empty & rsp_ready[h].
  - rsp_valence/rsp_arousal pass eng_valence/eng_arousal through combinationally.
  - On a fire, the FIFO pops.
- Full FIFO: the push is blocked even if a pop occurs in the same cycle. A simultaneous push and pop when not full is legal; the count is unchanged.
- Orphan result: eng_dout_valid with the FIFO empty sets err_orphan, and eng_dout_ready stays 0. err_orphan clears only on rst.
- FIFO pointers are log2(MAX_INFLIGHT)+1 bits and wrap naturally. The MSB distinguishes full from empty.

Optional Feature:
HDC_SCHED_STATS_EN
- Defined: adds output stat_jobs (NUM_REQ*16, per-requester completed-result counter, saturating at 16'hFFFF) and output stat_stall (32, cycles with eng_fin_valid & !eng_fin_ready, saturating). Both clear on rst.
- Undefined: neither port nor the counters exist.

Decomposition:
- Package hdc_sched_pkg holds:
  - the state enum {SEED_WAIT, SEED_LOAD, RUN};
  - the tag width function TAG_W = ceilLog2(NUM_REQ);
  - the localparam FIFO_PTR_W.
- One sub-module, hdc_sched_tag_fifo: synchronous FIFO with push/pop/full/empty/head and DEPTH/WIDTH parameters.

Test Plan:
- Seed load: seed_in=HV pattern 0xA5..., strobe in cycle 3 after reset -> eng_seed_hv_valid high exactly 2 cycles with eng_seed_hv=0xA5...; req_ready stays 0 until RUN.
- Round-robin: all 3 requesters valid, engine always ready -> grants 0,1,2,0,1,2 on successive fires; results return to rsp_valid[0],[1],[2] in the same order.
- Backpressure full: engine dout_ready path stalled (rsp_ready=0), 5 jobs offered -> exactly 4 accepted, then req_ready=0 and eng_fin_valid=0 until one result pops.
- Routing: requester 2 issues jobs with valence/arousal 1/0 and requester 0 with 0/1, interleaved -> each rsp_valid asserts only for its owner with matching labels; 380 mixed entries give zero mismatches.
- Orphan: force eng_dout_valid=1 with the FIFO empty -> err_orphan=1 next edge and stays 1; eng_dout_ready=0.
- Reset mid-op: rst with 3 jobs in flight -> next cycle FIFO empty, state SEED_WAIT, all rsp_valid=0; a new seed is needed before any req_ready.
